if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- IF/ID pipeline register for the 5-stage MIPS core. Captures the fetched instruction, PC and PC+4 from IF and presents them to the decoder, which builds the 22-bit control word for ID/EX.
- Implements stall (hold), flush (bubble insert) and branch delay-slot tagging.
- A small FSM defers delay-slot tagging when a taken branch coincides with a stall.

Parameters:
- DATA_WIDTH, 32: width of instruction, PC and NPC fields.
- NOP_INSTR, 32'h0000_0000: encoding loaded on reset, flush and bubble (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  DATA_WIDTH  PC of the instruction in IF.
- npc_in  input  DATA_WIDTH  PC+4 from IF.
- instr_in  input  DATA_WIDTH  instruction word from instruction memory.
- if_valid  input  1  IF holds a real instruction this cycle.
- stall  input  1  load-use hazard from the hazard unit; hold the register.
- flush  input  1  squash the IF instruction (exception/redirect).
- branch_taken  input  1  branch in ID resolved taken; the instruction entering this cycle is its delay slot.
- pc_out  output  DATA_WIDTH  registered PC.
- npc_out  output  DATA_WIDTH  registered PC+4.
- instr_out  output  DATA_WIDTH  registered instruction.
- valid_out  output  1  instr_out is a real instruction.
- delay_slot_out  output  1  instr_out is a branch delay slot.
- ds_pending  output  1  FSM is in DS_PEND (debug/visibility).

Behaviour:
- Synchronous, active-high reset; one clock (clk). Reset values:
  - pc_out = npc_out = 0, instr_out = NOP_INSTR.
  - valid_out = 0, delay_slot_out = 0, ds_pending = 0.
  - FSM = RUN.
- Update priority per edge: reset > flush > stall > load.
- Latency: 1 cycle from IF inputs to outputs when not stalled.
- Load (no flush, no stall):
  - pc_out <= pc_in, npc_out <= npc_in.
  - If if_valid = 1: instr_out <= instr_in, valid_out <= 1.
  - If if_valid = 0: instr_out <= NOP_INSTR, valid_out <= 0.
  - delay_slot_out <= (branch_taken in RUN) or (FSM in DS_PEND), and only if if_valid = 1; otherwise 0.
- Stall (no flush): all outputs hold their values.
- Flush:
  - instr_out <= NOP_INSTR, valid_out <= 0, delay_slot_out <= 0.
  - pc_out <= pc_in, npc_out <= npc_in.
  - FSM -> RUN. A stall in the same cycle is ignored.
- FSM states: RUN, DS_PEND.
  - RUN -> DS_PEND: branch_taken = 1 and stall = 1 and flush = 0.
  - DS_PEND -> RUN: first load cycle (stall = 0, flush = 0, if_valid = 1). That load sets delay_slot_out = 1.
  - DS_PEND with stall = 1: stay in DS_PEND.
  - DS_PEND with stall = 0 and if_valid = 0: load bubble, stay in DS_PEND until a valid instruction arrives.
  - DS_PEND with flush = 1: -> RUN, no tag applied.
  - branch_taken while in DS_PEND: ignored (no nested delay slots).
- ds_pending = 1 exactly when FSM = DS_PEND (registered).
- Reset asserted mid-stall or in DS_PEND: returns to reset values on that edge; any pending tag is dropped.
- No arithmetic; fields pass through unmodified.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each edge with stall = 1 and flush = 0.
  - flush_cnt increments on each edge with flush = 1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with instr_in = 32'h8C220004 -> instr_out = 0, valid_out = 0, pc_out = 0, delay_slot_out = 0.
- Normal load: pc_in = 0x10, npc_in = 0x14, instr_in = 0x8C220004, if_valid = 1 -> one edge later pc_out = 0x10, npc_out = 0x14, instr_out = 0x8C220004, valid_out = 1.
- Stall: after the load above, stall = 1 for 3 cycles with instr_in = 0x00430820 -> outputs hold 0x8C220004. On release, the next edge loads 0x00430820.
- Flush priority: flush = 1 and stall = 1 with pc_in = 0x20 -> instr_out = 0, valid_out = 0, pc_out = 0x20.
  - With IF_ID_PERF_EN defined: flush_cnt = 1, stall_cnt unchanged.
- Delay-slot deferral:
  - branch_taken = 1, stall = 1 -> ds_pending = 1, outputs held.
  - Next cycle stall = 0, if_valid = 1, instr_in = 0x20420001 -> instr_out = 0x20420001, delay_slot_out = 1, ds_pending = 0.
- Pending cancelled: enter DS_PEND, then flush = 1 -> ds_pending = 0. The next load has delay_slot_out = 0.

Source files
------------

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register for the 5-stage MIPS core.
//   Captures PC, PC+4 and the fetched instruction from IF for the decoder.
//   It supports stall (hold), flush (bubble insert) and branch delay-slot tagging.
//   A two-state FSM (RUN / DS_PEND) defers the delay-slot tag when a taken
//   branch coincides with a stall. The deferred tag is applied on the first
//   valid load that follows.
//
// Optional macro IF_ID_PERF_EN: adds saturating stall_cnt / flush_cnt outputs.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   pc_in, npc_in     PC and PC+4 of the instruction in IF
//   instr_in          instruction word from instruction memory
//   if_valid          IF holds a real instruction
//   stall             hold the register (load-use hazard)
//   flush             squash the IF instruction
//   branch_taken      branch in ID taken; the incoming instruction is its delay slot
//   pc_out, npc_out   registered PC / PC+4
//   instr_out         registered instruction (NOP_INSTR when a bubble is present)
//   valid_out         instr_out is a real instruction
//   delay_slot_out    instr_out is a branch delay slot
//   ds_pending        FSM is in DS_PEND
//   stall_cnt, flush_cnt  (IF_ID_PERF_EN only) saturating event counters
module if_id_stage #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] npc_in,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  if_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] npc_out,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  valid_out,
  output logic                  delay_slot_out,
  output logic                  ds_pending
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    RUN     = 1'b0,
    DS_PEND = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] pc_d, npc_d, instr_d;
  logic                  valid_d, ds_d;

  // A load happens only when neither flush nor stall is active
  logic load_c;
  assign load_c = !flush && !stall;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (branch_taken && stall) state_nxt = DS_PEND;
        // branch_taken is ignored here: no nested delay slots
        DS_PEND: if (!stall && if_valid)    state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Output logic: next values of the pipeline register
  always_comb begin
    pc_d    = pc_out;
    npc_d   = npc_out;
    instr_d = instr_out;
    valid_d = valid_out;
    ds_d    = delay_slot_out;
    if (flush) begin
      pc_d    = pc_in;
      npc_d   = npc_in;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      ds_d    = 1'b0;
    end else if (load_c) begin
      pc_d    = pc_in;
      npc_d   = npc_in;
      instr_d = if_valid ? instr_in : NOP_INSTR;
      valid_d = if_valid;
      // Tag either from a same-cycle taken branch or a deferred one
      ds_d    = if_valid && ((state == RUN && branch_taken) || state == DS_PEND);
    end
  end

  // Pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out         <= '0;
      npc_out        <= '0;
      instr_out      <= NOP_INSTR;
      valid_out      <= 1'b0;
      delay_slot_out <= 1'b0;
    end else begin
      pc_out         <= pc_d;
      npc_out        <= npc_d;
      instr_out      <= instr_d;
      valid_out      <= valid_d;
      delay_slot_out <= ds_d;
    end
  end

  // The single-bit state encoding makes ds_pending a direct flop output
  assign ds_pending = (state == DS_PEND);

`ifdef IF_ID_PERF_EN
  // Saturating hazard counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !flush && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= CNT_W'(stall_cnt + CNT_W'(1));
      if (flush && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= CNT_W'(flush_cnt + CNT_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed table followed by randomized
// stimulus compared against a behavioural model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, npc_in, instr_in;
  logic        if_valid, stall, flush, branch_taken;
  logic [31:0] pc_out, npc_out, instr_out;
  logic        valid_out, delay_slot_out, ds_pending;
`ifdef IF_ID_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_npc, m_instr;
  logic        m_valid, m_ds, m_pend;
  int          m_scnt, m_fcnt;

  always #5 clk = ~clk;

  if_id_stage #(.DATA_WIDTH(32), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .npc_in(npc_in),
    .instr_in(instr_in), .if_valid(if_valid), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .pc_out(pc_out), .npc_out(npc_out),
    .instr_out(instr_out), .valid_out(valid_out),
    .delay_slot_out(delay_slot_out), .ds_pending(ds_pending)
`ifdef IF_ID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc, npc, instr;
    logic        v, st, fl, bt;
    logic [31:0] e_pc, e_npc, e_instr;
    logic        e_v, e_ds, e_pend;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic rst, logic [31:0] pc, logic [31:0] npc,
                              logic [31:0] instr, logic v, logic st, logic fl,
                              logic bt, logic [31:0] e_pc, logic [31:0] e_npc,
                              logic [31:0] e_instr, logic e_v, logic e_ds,
                              logic e_pend);
    vec_t r;
    r.rst = rst; r.pc = pc; r.npc = npc; r.instr = instr;
    r.v = v; r.st = st; r.fl = fl; r.bt = bt;
    r.e_pc = e_pc; r.e_npc = e_npc; r.e_instr = e_instr;
    r.e_v = e_v; r.e_ds = e_ds; r.e_pend = e_pend;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec rules applied to the model for one clock edge
  task automatic model_edge();
    if (reset) begin
      m_pc = 0; m_npc = 0; m_instr = 0; m_valid = 0; m_ds = 0; m_pend = 0;
      m_scnt = 0; m_fcnt = 0;
    end else if (flush) begin
      m_pc = pc_in; m_npc = npc_in; m_instr = 0; m_valid = 0; m_ds = 0;
      m_pend = 0;
      if (m_fcnt < 65535) m_fcnt++;
    end else if (stall) begin
      if (!m_pend && branch_taken) m_pend = 1;
      if (m_scnt < 65535) m_scnt++;
    end else begin
      m_pc = pc_in; m_npc = npc_in;
      m_valid = if_valid;
      m_instr = if_valid ? instr_in : 32'h0;
      m_ds = if_valid && (m_pend || branch_taken);
      if (m_pend && if_valid) m_pend = 0;
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc, input logic [31:0] npc,
                       input logic [31:0] instr, input logic v, input logic st,
                       input logic fl, input logic bt);
    reset = rst; pc_in = pc; npc_in = npc; instr_in = instr;
    if_valid = v; stall = st; flush = fl; branch_taken = bt;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},    pc_out,    m_pc);
    chk({tag, ".npc"},   npc_out,   m_npc);
    chk({tag, ".instr"}, instr_out, m_instr);
    chk({tag, ".valid"}, 32'(valid_out),      32'(m_valid));
    chk({tag, ".ds"},    32'(delay_slot_out), 32'(m_ds));
    chk({tag, ".pend"},  32'(ds_pending),     32'(m_pend));
`ifdef IF_ID_PERF_EN
    chk({tag, ".scnt"},  32'(stall_cnt), 32'(m_scnt));
    chk({tag, ".fcnt"},  32'(flush_cnt), 32'(m_fcnt));
`endif
  endtask

  initial begin
    // rst pc npc instr v st fl bt | e_pc e_npc e_instr e_v e_ds e_pend
    tbl[0]  = mk(1, 32'h00, 32'h00, 32'h8C220004, 1,0,0,0, 32'h00, 32'h00, 32'h0,        0,0,0);
    tbl[1]  = mk(1, 32'h00, 32'h00, 32'h8C220004, 1,0,0,0, 32'h00, 32'h00, 32'h0,        0,0,0);
    tbl[2]  = mk(0, 32'h10, 32'h14, 32'h8C220004, 1,0,0,0, 32'h10, 32'h14, 32'h8C220004, 1,0,0);
    tbl[3]  = mk(0, 32'h18, 32'h1C, 32'h00430820, 1,1,0,0, 32'h10, 32'h14, 32'h8C220004, 1,0,0);
    tbl[4]  = mk(0, 32'h18, 32'h1C, 32'h00430820, 1,1,0,0, 32'h10, 32'h14, 32'h8C220004, 1,0,0);
    tbl[5]  = mk(0, 32'h18, 32'h1C, 32'h00430820, 1,1,0,0, 32'h10, 32'h14, 32'h8C220004, 1,0,0);
    tbl[6]  = mk(0, 32'h18, 32'h1C, 32'h00430820, 1,0,0,0, 32'h18, 32'h1C, 32'h00430820, 1,0,0);
    tbl[7]  = mk(0, 32'h20, 32'h24, 32'h12345678, 1,1,1,0, 32'h20, 32'h24, 32'h0,        0,0,0);
    tbl[8]  = mk(0, 32'h24, 32'h28, 32'h10000003, 1,0,0,0, 32'h24, 32'h28, 32'h10000003, 1,0,0);
    tbl[9]  = mk(0, 32'h28, 32'h2C, 32'h20420001, 1,1,0,1, 32'h24, 32'h28, 32'h10000003, 1,0,1);
    tbl[10] = mk(0, 32'h28, 32'h2C, 32'h20420001, 1,0,0,0, 32'h28, 32'h2C, 32'h20420001, 1,1,0);
    tbl[11] = mk(0, 32'h2C, 32'h30, 32'hAAAAAAAA, 1,1,0,1, 32'h28, 32'h2C, 32'h20420001, 1,1,1);
    tbl[12] = mk(0, 32'h2C, 32'h30, 32'hAAAAAAAA, 1,0,1,0, 32'h2C, 32'h30, 32'h0,        0,0,0);
    tbl[13] = mk(0, 32'h30, 32'h34, 32'h00000820, 1,0,0,0, 32'h30, 32'h34, 32'h00000820, 1,0,0);
    tbl[14] = mk(0, 32'h34, 32'h38, 32'hBBBBBBBB, 1,1,0,1, 32'h30, 32'h34, 32'h00000820, 1,0,1);
    tbl[15] = mk(0, 32'h34, 32'h38, 32'hBBBBBBBB, 0,0,0,0, 32'h34, 32'h38, 32'h0,        0,0,1);
    tbl[16] = mk(0, 32'h38, 32'h3C, 32'h01234567, 1,0,0,1, 32'h38, 32'h3C, 32'h01234567, 1,1,0);
    tbl[17] = mk(0, 32'h3C, 32'h40, 32'h11111111, 1,0,0,1, 32'h3C, 32'h40, 32'h11111111, 1,1,0);
    tbl[18] = mk(0, 32'h40, 32'h44, 32'h22222222, 1,1,0,1, 32'h3C, 32'h40, 32'h11111111, 1,1,1);
    tbl[19] = mk(1, 32'h40, 32'h44, 32'h22222222, 1,1,0,0, 32'h00, 32'h00, 32'h0,        0,0,0);
    tbl[20] = mk(0, 32'h40, 32'h44, 32'h22222222, 1,0,0,0, 32'h40, 32'h44, 32'h22222222, 1,0,0);

    reset = 1; pc_in = 0; npc_in = 0; instr_in = 0;
    if_valid = 0; stall = 0; flush = 0; branch_taken = 0;
    m_pc = 0; m_npc = 0; m_instr = 0; m_valid = 0; m_ds = 0; m_pend = 0;
    m_scnt = 0; m_fcnt = 0;
    @(negedge clk);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].rst, tbl[i].pc, tbl[i].npc, tbl[i].instr,
            tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].bt);
      chk({tag, ".pc"},    pc_out,    tbl[i].e_pc);
      chk({tag, ".npc"},   npc_out,   tbl[i].e_npc);
      chk({tag, ".instr"}, instr_out, tbl[i].e_instr);
      chk({tag, ".valid"}, 32'(valid_out),      32'(tbl[i].e_v));
      chk({tag, ".ds"},    32'(delay_slot_out), 32'(tbl[i].e_ds));
      chk({tag, ".pend"},  32'(ds_pending),     32'(tbl[i].e_pend));
`ifdef IF_ID_PERF_EN
      // Stalls at rows 3-5 and the flush at row 7 precede the final reset
      if (i == 7) begin
        chk("perf.flush_cnt", 32'(flush_cnt), 32'd1);
        chk("perf.stall_cnt", 32'(stall_cnt), 32'd3);
      end
      chk({tag, ".scnt"}, 32'(stall_cnt), 32'(m_scnt));
      chk({tag, ".fcnt"}, 32'(flush_cnt), 32'(m_fcnt));
`endif
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc = $urandom() & 32'hFFFF_FFFC;
      drive(($urandom_range(0, 49) == 0),
            pc, pc + 32'd4, $urandom(),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
